vrampx_arbiter: RTL and testbench
=================================

// Module: vrampx_arbiter
// PURPOSE
//  Shares the single-port pixel-plane VRAM between the pixel engine's scanout reads and CPU reads/writes.
//  Scanout always wins and keeps fixed 1-cycle read latency. CPU writes are posted through a small FIFO;
//  CPU reads wait until that FIFO is empty so they see all earlier writes.
//  Sits between the memory-unit VRAM port and the GPU pixel engine, in the clkMuxOut domain.
// PARAMETERS
//  ADDR_W      17  VRAM address width
//  DATA_W       8  VRAM data width
//  FIFO_AW      2  log2 of write-FIFO depth (depth = 4)
// PORTS
//  clk          in   1       single clock; all logic on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  gpu_req      in   1       scanout read request this cycle
//  gpu_addr     in   ADDR_W  scanout read address
//  gpu_q        out  DATA_W  scanout data; valid the cycle after gpu_req
//  cpu_req      in   1       CPU request; held until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read; stable while cpu_req is high
//  cpu_addr     in   ADDR_W  CPU address; stable while cpu_req is high
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_ack      out  1       1-cycle completion pulse, registered
//  cpu_rdata    out  DATA_W  read data; valid while cpu_ack is high, then held
//  fifo_level   out  FIFO_AW+1  number of posted writes not yet committed
//  ram_addr     out  ADDR_W  VRAM address
//  ram_d        out  DATA_W  VRAM write data
//  ram_we       out  1       VRAM write enable
//  ram_q        in   DATA_W  VRAM read data; synchronous, 1-cycle latency
// BEHAVIOUR
//  Reset: cpu_ack=0, cpu_rdata=0, FIFO empty (fifo_level=0), state IDLE, internal regs 0.
//  Port mux (combinational), in priority order:
//    - gpu_req=1: ram_addr=gpu_addr, ram_we=0.
//    - else state DRAIN: ram_addr/ram_d = FIFO head, ram_we=1.
//    - else state RD: ram_addr=cpu_addr, ram_we=0.
//    - else ram_we=0 and ram_addr=gpu_addr.
//  gpu_q = ram_q (passthrough). The GPU never stalls and never sees CPU traffic.
//  Write accept: the arbiter accepts a write when cpu_req & cpu_we & ~cpu_ack & (level<depth).
//    - On accept, push to the FIFO; cpu_ack=1 on the next cycle.
//    - While cpu_ack=1, cpu_req is ignored; the requester drops or changes req in that cycle.
//  FIFO full: the write is not accepted and cpu_req stays pending, with no ack.
//  FSM states IDLE, DRAIN, RD, RDW:
//    - IDLE -> DRAIN when the FIFO is non-empty.
//    - IDLE -> RD on cpu_req & ~cpu_we & ~cpu_ack & FIFO empty.
//    - DRAIN: pop only in cycles with gpu_req=0 (write committed).
//      Stay in DRAIN until empty, then go to IDLE.
//    - RD: a cycle with gpu_req=0 issues the read and moves to RDW.
//      With gpu_req=1, remain in RD (retry).
//    - RDW: cpu_rdata<=ram_q, cpu_ack<=1, then go to IDLE.
//      The read already issued, so a gpu_req in RDW does not affect it.
//  Minimum CPU read: ack 3 clk edges after req is first sampled with gpu_req low.
//  Minimum CPU write: ack 1 edge after req is first sampled.
//  Push and pop in the same cycle: level unchanged. Pointers wrap modulo 2^FIFO_AW.
//    Full = level==2^FIFO_AW.
//  Writes accepted while in RD/RDW are legal only in a following transaction; reads are
//    serialized behind them.
//  Continuous gpu_req (active line) starves the CPU until blanking.
//    No timeout; this is intended.
//  Reset mid-operation: posted writes are discarded, any read in flight is dropped with no ack,
//    and the FSM returns to IDLE. A CPU req still high after reset is served as new.
// CONFIGURATION
//  VRAMPX_ARB_STATS_EN defined adds two ports:
//    - stats_clr  in  1   synchronous clear of the counter
//    - stall_cnt  out 16  cycles with cpu_req=1 & cpu_ack=0; saturates at 16'hFFFF; reset 0
//  Undefined: those ports and the counter do not exist. Arbitration behaviour is identical either way.
// TESTING
//  1. Idle GPU. CPU write 0x155AA<=8'h3C, then read 0x155AA:
//     write acked next cycle, ram_we pulses once, read acks with cpu_rdata=8'h3C.
//  2. gpu_req held for 100 cycles while CPU posts 5 writes:
//     4 writes acked, fifo_level=4, 5th unacked, ram_we=0 throughout, gpu_q tracks ram_q.
//     After gpu_req drops, writes commit in order and the 5th is acked.
//  3. Write A<=8'h11, immediately read A with gpu_req toggling every cycle:
//     the read acks only after the write commits; cpu_rdata=8'h11.
//  4. Pointer wrap: 10 back-to-back writes to 0x00000..0x00009, GPU idle:
//     RAM holds data0..data9 in order; fifo_level returns to 0.
//  5. Assert reset_n=0 during RD with 2 posted writes:
//     cpu_ack=0, fifo_level=0, no ram_we after reset; a held req is re-served correctly.
//  6. (STATS_EN) 50 stalled cycles: stall_cnt=50; stats_clr -> 0; a long stall saturates at 16'hFFFF.

Source files
------------

// File: rtl/vrampx_arbiter_if.sv
// vrampx_arbiter_if: bundles the scanout, CPU and VRAM-port signals of the
// pixel-plane VRAM arbiter. The arbiter uses the slave view; the pixel engine,
// CPU and memory unit together form the master view.
`timescale 1ns/1ps

interface vrampx_arbiter_if #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2
);
  // scanout read port
  logic              gpu_req;
  logic [ADDR_W-1:0] gpu_addr;
  logic [DATA_W-1:0] gpu_q;
  // CPU request port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [FIFO_AW:0]  fifo_level;
  // single-port VRAM
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  gpu_req, gpu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
    output gpu_q, cpu_ack, cpu_rdata, fifo_level, ram_addr, ram_d, ram_we
  );

  modport master (
    output gpu_req, gpu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
    input  gpu_q, cpu_ack, cpu_rdata, fifo_level, ram_addr, ram_d, ram_we
  );
endinterface

// File: rtl/vrampx_arbiter.sv
// vrampx_arbiter: shares the single-port pixel-plane VRAM between scanout
// reads (always highest priority, fixed 1-cycle latency) and CPU accesses.
// CPU writes are posted through a small FIFO; CPU reads wait for the FIFO to
// drain so they observe every earlier write.
// Optional feature: define VRAMPX_ARB_STATS_EN to add stats_clr/stall_cnt,
// a saturating count of cycles in which a CPU request waits for its ack.
`timescale 1ns/1ps

module vrampx_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef VRAMPX_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] stall_cnt,
`endif
  vrampx_arbiter_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LVL_W = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, RD, RDW} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  state_t             state, state_nxt;
  wr_entry_t          fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  assign fifo_full  = (level == LVL_W'(DEPTH));
  assign fifo_empty = (level == '0);

  // A write is posted whenever there is room; a held request is ignored
  // during its own ack cycle so it cannot be pushed twice.
  assign push = bus.cpu_req & bus.cpu_we & ~bus.cpu_ack & ~fifo_full;
  // The FIFO head commits only in cycles scanout leaves the port free.
  assign pop  = (state == DRAIN) & ~bus.gpu_req & ~fifo_empty;

  assign bus.gpu_q      = bus.ram_q;
  assign bus.fifo_level = level;

  // Next-state logic for the drain/read sequencer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty)
          state_nxt = DRAIN;
        else if (bus.cpu_req && !bus.cpu_we && !bus.cpu_ack)
          state_nxt = RD;
      end
      DRAIN: begin
        if (fifo_empty || (pop && !push && level == LVL_W'(1)))
          state_nxt = IDLE;
      end
      RD: begin
        if (!bus.gpu_req)
          state_nxt = RDW;
      end
      RDW:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // VRAM port mux: scanout, then FIFO drain, then CPU read, else parked on scanout.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = bus.gpu_addr;
    bus.ram_d    = fifo_mem[rd_ptr].data;
    if (!bus.gpu_req) begin
      if (state == DRAIN) begin
        bus.ram_addr = fifo_mem[rd_ptr].addr;
        bus.ram_we   = pop;
      end else if (state == RD) begin
        bus.ram_addr = bus.cpu_addr;
      end
    end
  end

  // State register, FIFO pointers/level and the registered CPU response.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      bus.cpu_ack <= push | (state == RDW);
      if (state == RDW) bus.cpu_rdata <= bus.ram_q;
    end
  end

  // Write-FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: this storage is only four entries, so it is cleared with the other registers; a deep RAM-backed FIFO would leave its array unreset.
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= '{addr: bus.cpu_addr, data: bus.cpu_wdata};
    end
  end

`ifdef VRAMPX_ARB_STATS_EN
  // Saturating count of cycles a CPU request is waiting for its ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (stats_clr)
      stall_cnt <= '0;
    else if (bus.cpu_req && !bus.cpu_ack && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vrampx_arbiter.sv
// tb_vrampx_arbiter: self-checking bench for vrampx_arbiter. A behavioural
// synchronous VRAM sits on the RAM port, a scanout driver runs in one of three
// modes (off, continuous, toggling) and checks gpu_q against a known pattern,
// and the main sequence drives the CPU port with table vectors plus directed
// multi-cycle scenarios.
`timescale 1ns/1ps

module tb_vrampx_arbiter;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int FIFO_AW = 2;
  localparam logic [ADDR_W-1:0] GPU_BASE = 17'h01000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vrampx_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) bus ();

`ifdef VRAMPX_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] stall_cnt;
`endif

  vrampx_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef VRAMPX_ARB_STATS_EN
    .stats_clr (stats_clr),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
    return a[7:0] * 8'd7 + 8'd3;
  endfunction

  // Behavioural synchronous VRAM plus a log of every committed write.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W+DATA_W-1:0] wlog [$];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_d;
      wlog.push_back({bus.ram_addr, bus.ram_d});
    end
    bus.ram_q <= mem[bus.ram_addr];
  end

  // Scanout driver: 0 = off, 1 = continuous, 2 = toggling every cycle.
  int gpu_mode = 0;
  int gpu_bad  = 0;
  int gpu_seen = 0;
  initial begin : gpu_drv
    logic              prev_req;
    logic [ADDR_W-1:0] prev_addr;
    int                phase;
    bus.gpu_req  = 1'b0;
    bus.gpu_addr = '0;
    prev_req     = 1'b0;
    prev_addr    = '0;
    phase        = 0;
    forever begin
      @(posedge clk);
      #2;
      if (prev_req) begin
        gpu_seen++;
        if (bus.gpu_q !== pat(prev_addr)) gpu_bad++;
      end
      phase++;
      case (gpu_mode)
        1: begin
          bus.gpu_req  = 1'b1;
          bus.gpu_addr = GPU_BASE + ADDR_W'(phase % 16);
        end
        2: begin
          bus.gpu_req  = ~bus.gpu_req;
          bus.gpu_addr = GPU_BASE + ADDR_W'(phase % 16);
        end
        default: begin
          bus.gpu_req  = 1'b0;
          bus.gpu_addr = '0;
        end
      endcase
      prev_req  = bus.gpu_req;
      prev_addr = bus.gpu_addr;
    end
  end

  task automatic wait_ack(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output bit ok);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    wait_ack(8, ok);
    bus.cpu_req = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input int max, output bit ok);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = a;
    wait_ack(max, ok);
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_empty(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (bus.fifo_level == '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              exp_ack;
    logic [FIFO_AW:0]  exp_level;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_raddr;
    logic              chk_rd;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  localparam logic [ADDR_W-1:0] A1 = 17'h155AA;
  localparam logic [ADDR_W-1:0] A3 = 17'h02222;
  localparam logic [ADDR_W-1:0] A5 = 17'h03000;

  vec_t vecs [8];

  initial begin : main
    bit ok;
    int n0, acks, seen, errs;

    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 8'h00;
    for (int i = 0; i < 16; i++) mem[GPU_BASE + ADDR_W'(i)] <= pat(GPU_BASE + ADDR_W'(i));
    mem[A5]          <= 8'h77;
    mem[A5 + 17'd1]  <= 8'h78;

    // Test 1: idle GPU, write 0x155AA <= 3C then read it back, cycle by cycle.
    //            req we  addr   wdata  ack lvl we  raddr  chk rdata
    vecs[0] = '{1'b1, 1'b1, A1, 8'h3C, 1'b0, 3'd0, 1'b0, 17'h0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, A1, 8'h00, 1'b1, 3'd1, 1'b0, 17'h0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b0, A1, 8'h00, 1'b0, 3'd1, 1'b1, A1,    1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, A1, 8'h00, 1'b0, 3'd0, 1'b0, 17'h0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, A1, 8'h00, 1'b0, 3'd0, 1'b0, A1,    1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, A1, 8'h00, 1'b0, 3'd0, 1'b0, 17'h0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b0, A1, 8'h00, 1'b1, 3'd0, 1'b0, 17'h0, 1'b1, 8'h3C};
    vecs[7] = '{1'b0, 1'b0, A1, 8'h00, 1'b0, 3'd0, 1'b0, 17'h0, 1'b1, 8'h3C};

    repeat (3) @(negedge clk);
    check("reset_ack",   {31'd0, bus.cpu_ack}, 32'd0);
    check("reset_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
    check("reset_level", {29'd0, bus.fifo_level}, 32'd0);
    check("reset_ram_we", {31'd0, bus.ram_we}, 32'd0);
    reset_n = 1'b1;

    n0 = wlog.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.cpu_req   = vecs[i].cpu_req;
      bus.cpu_we    = vecs[i].cpu_we;
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_wdata = vecs[i].wdata;
      #1;
      check($sformatf("t1_v%0d_ack", i),   {31'd0, bus.cpu_ack}, {31'd0, vecs[i].exp_ack});
      check($sformatf("t1_v%0d_level", i), {29'd0, bus.fifo_level}, {29'd0, vecs[i].exp_level});
      check($sformatf("t1_v%0d_ram_we", i), {31'd0, bus.ram_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("t1_v%0d_ram_addr", i), {15'd0, bus.ram_addr}, {15'd0, vecs[i].exp_raddr});
      if (vecs[i].chk_rd)
        check($sformatf("t1_v%0d_rdata", i), {24'd0, bus.cpu_rdata}, {24'd0, vecs[i].exp_rdata});
    end
    check("t1_ram_we_pulses", wlog.size() - n0, 32'd1);
    bus.cpu_req = 1'b0;

    // Test 2: continuous scanout, five writes posted, only four fit.
    gpu_mode = 1;
    repeat (2) @(negedge clk);
    n0 = wlog.size();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_write(17'h00100 + ADDR_W'(i), 8'hA0 + 8'(i), ok);
      acks += int'(ok);
    end
    check("t2_four_acked", acks, 32'd4);
    check("t2_level_full", {29'd0, bus.fifo_level}, 32'd4);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 17'h00104;
    bus.cpu_wdata = 8'hA4;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.cpu_ack) seen++;
    end
    check("t2_fifth_not_acked", seen, 32'd0);
    check("t2_level_still_full", {29'd0, bus.fifo_level}, 32'd4);
    repeat (75) @(negedge clk);
    check("t2_no_ram_we_during_scan", wlog.size() - n0, 32'd0);
    gpu_mode = 0;
    wait_ack(20, ok);
    check("t2_fifth_acked", {31'd0, ok}, 32'd1);
    bus.cpu_req = 1'b0;
    wait_empty(20, ok);
    check("t2_drained", {31'd0, ok}, 32'd1);
    check("t2_commit_count", wlog.size() - n0, 32'd5);
    errs = 0;
    for (int i = 0; i < 5; i++)
      if (n0 + i >= wlog.size() || wlog[n0 + i] !== {17'h00100 + ADDR_W'(i), 8'hA0 + 8'(i)}) errs++;
    check("t2_commit_order", errs, 32'd0);

    // Test 3: write then immediate read of the same address, scanout toggling.
    gpu_mode = 2;
    repeat (2) @(negedge clk);
    n0 = wlog.size();
    cpu_write(A3, 8'h11, ok);
    check("t3_write_acked", {31'd0, ok}, 32'd1);
    cpu_read(A3, 60, ok);
    check("t3_read_acked", {31'd0, ok}, 32'd1);
    check("t3_write_before_read", wlog.size() - n0, 32'd1);
    if (wlog.size() > n0)
      check("t3_commit_entry", {7'd0, wlog[wlog.size() - 1]}, {7'd0, A3, 8'h11});
    check("t3_rdata", {24'd0, bus.cpu_rdata}, 32'h11);
    gpu_mode = 0;

    // Test 4: ten back-to-back writes wrap the FIFO pointers.
    repeat (2) @(negedge clk);
    n0 = wlog.size();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      cpu_write(ADDR_W'(i), 8'hC0 + 8'(i), ok);
      acks += int'(ok);
    end
    check("t4_all_acked", acks, 32'd10);
    wait_empty(20, ok);
    check("t4_level_zero", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    check("t4_commit_count", wlog.size() - n0, 32'd10);
    errs = 0;
    for (int i = 0; i < 10; i++)
      if (mem[i] !== 8'hC0 + 8'(i)) errs++;
    check("t4_ram_contents", errs, 32'd0);

    // Test 5a: reset with two posted writes and a read pending.
    gpu_mode = 1;
    repeat (2) @(negedge clk);
    cpu_write(A5, 8'hE0, ok);
    cpu_write(A5 + 17'd1, 8'hE1, ok);
    check("t5_level_two", {29'd0, bus.fifo_level}, 32'd2);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = A5;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_reset_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("t5_reset_level", {29'd0, bus.fifo_level}, 32'd0);
    n0 = wlog.size();
    gpu_mode = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(20, ok);
    check("t5_reread_acked", {31'd0, ok}, 32'd1);
    check("t5_reread_data", {24'd0, bus.cpu_rdata}, 32'h77);
    bus.cpu_req = 1'b0;
    check("t5_no_ram_we_after_reset", wlog.size() - n0, 32'd0);

    // Test 5b: reset while the read is retrying in RD behind scanout.
    gpu_mode = 1;
    repeat (2) @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = A5 + 17'd1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.cpu_ack) seen++;
    end
    check("t5b_read_starved", seen, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t5b_reset_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
    gpu_mode = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(20, ok);
    check("t5b_reread_acked", {31'd0, ok}, 32'd1);
    check("t5b_reread_data", {24'd0, bus.cpu_rdata}, 32'h78);
    bus.cpu_req = 1'b0;

`ifdef VRAMPX_ARB_STATS_EN
    // Test 6: stall counter counts, clears and saturates.
    gpu_mode = 1;
    repeat (2) @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr    = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = A5;
    repeat (50) @(negedge clk);
    check("t6_stall_50", {16'd0, stall_cnt}, 32'd50);
    stats_clr = 1'b1;
    @(negedge clk);
    check("t6_stall_clr", {16'd0, stall_cnt}, 32'd0);
    stats_clr = 1'b0;
    repeat (65540) @(negedge clk);
    check("t6_stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    gpu_mode = 0;
    wait_ack(20, ok);
    check("t6_read_acked", {31'd0, ok}, 32'd1);
    bus.cpu_req = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("gpu_q_track", gpu_bad, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
